i2s_transmitter: RTL and testbench

Serializes 16-bit stereo PCM into an I2S stream for the audio codec. Sits directly downstream of the mixer and generates its own bit clock and word-select outputs by dividing the 100 MHz system clock internally, in the same even-ratio fashion as the shared clock divider, so everything stays in one clock domain. A one-entry holding register with a valid/ready handshake decouples the sample producer from frame timing.

---
 rtl/audio_pkg.sv | 22 ++
 rtl/i2s_bclk_gen.sv | 54 +++++
 rtl/i2s_transmitter.sv | 148 ++++++++++++++
 tb/tb_i2s_transmitter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared audio-path definitions.
// Holds the default PCM channel width, the stereo sample record that the
// transmitter holds and shifts, the slot-index type, and a helper for the
// last slot of a frame.
package audio_pkg;

    localparam int SAMPLE_WIDTH_DEFAULT = 16;
    localparam int SLOT_IDX_W           = $clog2(2 * SAMPLE_WIDTH_DEFAULT);

    typedef struct packed {
        logic [SAMPLE_WIDTH_DEFAULT-1:0] left;
        logic [SAMPLE_WIDTH_DEFAULT-1:0] right;
    } stereo_sample_t;

    typedef logic [SLOT_IDX_W-1:0] slot_idx_t;

    // Index of the final bclk slot of a frame carrying two w-bit words.
    function automatic int frame_last_slot(input int w);
        return (2 * w) - 1;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides the system clock by an even ratio to form the I2S
// bit-clock phase and reports its edges as single-cycle strobes.
//   clk_i      : system clock
//   rst_n_i    : asynchronous active-low reset (clears count and phase)
//   rise_evt_o : high in the cycle whose closing edge drives bclk 0->1
//   fall_evt_o : high in the cycle whose closing edge drives bclk 1->0
// The strobes are combinational so that registers in the parent update on the
// same clock edge at which the bclk phase flips.
module i2s_bclk_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic rise_evt_o,
    output logic fall_evt_o
);

    localparam int HALF  = BCLK_DIV / 2;
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             wrap_s;

    // Half-period counter and phase toggle on wrap.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        wrap_s  = (cnt_q == CNT_LAST);
        if (wrap_s) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            phase_d = phase_q;
        end
    end

    // Counter and phase registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign rise_evt_o = wrap_s & ~phase_q;
    assign fall_evt_o = wrap_s &  phase_q;

endmodule

// File: rtl/i2s_transmitter.sv
// i2s_transmitter: serializes stereo PCM words into a standard I2S stream
// (one-bit data delay after word select, MSB first) with bclk derived from
// the system clock.
//   clk_in / rst_n_in         : system clock, asynchronous active-low reset
//   sample_valid_in/ready_out : one-entry holding register handshake
//   left_in / right_in        : channel words captured on valid && ready
//   bclk_out / lrclk_out      : bit clock and word select (0 = left)
//   sdata_out                 : serial data
//   frame_start_out           : pulse on every frame load
//   underrun_out              : pulse when a frame loads with nothing held
module i2s_transmitter #(
    parameter int BCLK_DIV     = 4,
    parameter int SAMPLE_WIDTH = audio_pkg::SAMPLE_WIDTH_DEFAULT
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    sample_valid_in,
    output logic                    sample_ready_out,
    input  logic [SAMPLE_WIDTH-1:0] left_in,
    input  logic [SAMPLE_WIDTH-1:0] right_in,
    output logic                    bclk_out,
    output logic                    lrclk_out,
    output logic                    sdata_out,
    output logic                    frame_start_out,
    output logic                    underrun_out
);

    import audio_pkg::*;

    localparam int FRAME_W = 2 * SAMPLE_WIDTH;
    localparam int SLOT_W  = $clog2(FRAME_W);
    localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(frame_last_slot(SAMPLE_WIDTH));
    localparam logic [SLOT_W-1:0] RIGHT_SLOT = SLOT_W'(SAMPLE_WIDTH);

    logic               rise_evt_s, fall_evt_s;
    logic               load_now_s, accept_s;
    logic               hold_full_q, hold_full_d;
    logic [FRAME_W-1:0] hold_q, hold_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic               bclk_q, bclk_d;
    logic               lrclk_q, lrclk_d;
    logic               sdata_q, sdata_d;
    logic               frame_start_q, frame_start_d;
    logic               underrun_q, underrun_d;

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk_i      (clk_in),
        .rst_n_i    (rst_n_in),
        .rise_evt_o (rise_evt_s),
        .fall_evt_o (fall_evt_s)
    );

    // Handshake: the held sample frees up on the very cycle it is loaded,
    // so a new sample can be accepted back-to-back. Ready is forced low
    // while reset is asserted so every output reads 0 in reset.
    always_comb begin
        load_now_s       = fall_evt_s && (slot_q == LAST_SLOT);
        sample_ready_out = rst_n_in && (!hold_full_q || load_now_s);
        accept_s         = sample_valid_in && sample_ready_out;
    end

    // Next-state for holding register, bclk level, slot, shifter and pulses.
    always_comb begin
        hold_full_d   = hold_full_q;
        hold_d        = hold_q;
        bclk_d        = bclk_q;
        slot_d        = slot_q;
        shift_d       = shift_q;
        lrclk_d       = lrclk_q;
        sdata_d       = sdata_q;
        frame_start_d = load_now_s;
        underrun_d    = load_now_s && !hold_full_q;

        // An accept on the load cycle refills the register after the old
        // content has gone to the shifter.
        if (accept_s) begin
            hold_full_d = 1'b1;
            hold_d      = {left_in, right_in};
        end else if (load_now_s) begin
            hold_full_d = 1'b0;
        end else begin
            hold_full_d = hold_full_q;
        end

        if (rise_evt_s) begin
            bclk_d = 1'b1;
        end else if (fall_evt_s) begin
            bclk_d = 1'b0;
        end else begin
            bclk_d = bclk_q;
        end

        // The shifter MSB always holds the bit for the slot being entered:
        // after 2W-1 shifts it is the previous right-word LSB, which gives
        // the one-bit I2S delay at slot 0 without a separate register.
        if (fall_evt_s) begin
            sdata_d = shift_q[FRAME_W-1];
            if (load_now_s) begin
                slot_d  = '0;
                shift_d = hold_full_q ? hold_q : '0;
            end else begin
                slot_d  = slot_q + SLOT_W'(1);
                shift_d = {shift_q[FRAME_W-2:0], 1'b0};
            end
            lrclk_d = (slot_d >= RIGHT_SLOT);
        end else begin
            sdata_d = sdata_q;
            slot_d  = slot_q;
            shift_d = shift_q;
            lrclk_d = lrclk_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hold_full_q   <= 1'b0;
            hold_q        <= '0;
            bclk_q        <= 1'b0;
            slot_q        <= LAST_SLOT;
            shift_q       <= '0;
            lrclk_q       <= 1'b0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            hold_full_q   <= hold_full_d;
            hold_q        <= hold_d;
            bclk_q        <= bclk_d;
            slot_q        <= slot_d;
            shift_q       <= shift_d;
            lrclk_q       <= lrclk_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign bclk_out        = bclk_q;
    assign lrclk_out       = lrclk_q;
    assign sdata_out       = sdata_q;
    assign frame_start_out = frame_start_q;
    assign underrun_out    = underrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: two instances (BCLK_DIV 4 and 8) share stimulus.
// A frame-level model (cycle count -> bclk phase, slot, frame index) predicts
// every output each cycle; literal checks pin the model at known points.
module tb_i2s_transmitter;

    localparam int W = 16;
    localparam int F = 2 * W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] left = 16'h0000;
    logic [15:0] right = 16'h0000;
    logic [1:0]  rdy, bclk, lrclk, sdata, fs, ur;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    i2s_transmitter #(.BCLK_DIV(4), .SAMPLE_WIDTH(W)) u_dut4 (
        .clk_in(clk), .rst_n_in(rst_n), .sample_valid_in(valid),
        .sample_ready_out(rdy[0]), .left_in(left), .right_in(right),
        .bclk_out(bclk[0]), .lrclk_out(lrclk[0]), .sdata_out(sdata[0]),
        .frame_start_out(fs[0]), .underrun_out(ur[0]));

    i2s_transmitter #(.BCLK_DIV(8), .SAMPLE_WIDTH(W)) u_dut8 (
        .clk_in(clk), .rst_n_in(rst_n), .sample_valid_in(valid),
        .sample_ready_out(rdy[1]), .left_in(left), .right_in(right),
        .bclk_out(bclk[1]), .lrclk_out(lrclk[1]), .sdata_out(sdata[1]),
        .frame_start_out(fs[1]), .underrun_out(ur[1]));

    // ---------------- reference model ----------------
    int          t [2];
    bit          full [2];
    logic [31:0] hold [2];
    logic [31:0] frames [2][64];
    bit          und [2][64];

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 8;
    endfunction

    // true when the clock edge numbered tt (since reset release) loads a frame
    function automatic bit is_load(input int tt, input int dv);
        return (tt > 0) && (tt % dv == 0) && (((tt / dv) - 1) % F == 0);
    endfunction

    task automatic cmp(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %h expected %h at %0t", name, inst, act, exp, $time);
        end
    endtask

    initial begin
        audio_pkg::stereo_sample_t smp;
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    t[i] = 0;
                    full[i] = 1'b0;
                end else begin
                    bit ld;
                    bit acc;
                    int f;
                    t[i]++;
                    ld  = is_load(t[i], div_of(i));
                    acc = valid && (!full[i] || ld);
                    if (ld) begin
                        f = (t[i] / div_of(i) - 1) / F;
                        frames[i][f % 64] = full[i] ? hold[i] : 32'h0;
                        und[i][f % 64] = !full[i];
                        full[i] = 1'b0;
                    end
                    if (acc) begin
                        smp.left  = left;
                        smp.right = right;
                        hold[i]   = smp;
                        full[i]   = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 2; i++) begin
                logic e_b, e_l, e_d, e_fs, e_ur, e_r;
                logic [31:0] fr;
                int dv, n, s, f;
                dv = div_of(i);
                e_b = 1'b0; e_l = 1'b0; e_d = 1'b0; e_fs = 1'b0; e_ur = 1'b0; e_r = 1'b0;
                if (rst_n) begin
                    e_b = ((t[i] / (dv / 2)) % 2) == 1;
                    n = t[i] / dv;
                    if (n > 0) begin
                        s = (n - 1) % F;
                        f = (n - 1) / F;
                        e_l = (s >= W);
                        if (s == 0) begin
                            if (f > 0) begin
                                fr  = frames[i][(f - 1) % 64];
                                e_d = fr[0];
                            end
                        end else begin
                            fr  = frames[i][f % 64];
                            e_d = fr[F - s];
                        end
                        e_fs = (t[i] % dv == 0) && (s == 0);
                        e_ur = e_fs && und[i][f % 64];
                    end
                    e_r = !full[i] || is_load(t[i] + 1, dv);
                end
                cmp("bclk", i, {31'd0, bclk[i]}, {31'd0, e_b});
                cmp("lrclk", i, {31'd0, lrclk[i]}, {31'd0, e_l});
                cmp("sdata", i, {31'd0, sdata[i]}, {31'd0, e_d});
                cmp("frame_start", i, {31'd0, fs[i]}, {31'd0, e_fs});
                cmp("underrun", i, {31'd0, ur[i]}, {31'd0, e_ur});
                cmp("ready", i, {31'd0, rdy[i]}, {31'd0, e_r});
            end
        end
    end

    // ---------------- stimulus and literal checks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // advance to 2 time units after clock edge k (k counted from release)
    task automatic wait_t(input int k);
        int guard;
        guard = 0;
        while (t[0] < k && guard < 20000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (t[0] < k) begin
            failures++;
            $display("FAIL wait_t: reached %0d required %0d", t[0], k);
        end
        #1;
    endtask

    initial begin
        logic [15:0] bits;
        int n_acc;
        logic [15:0] cnt;
        logic r;

        // idle: no samples, timing and underrun cadence
        do_reset();
        wait_t(1);   cmp("idle_bclk_t1", 0, {31'd0, bclk[0]}, 32'd0);
        wait_t(2);   cmp("idle_bclk_t2", 0, {31'd0, bclk[0]}, 32'd1);
        wait_t(3);   cmp("div8_bclk_t3", 1, {31'd0, bclk[1]}, 32'd0);
        wait_t(4);   cmp("idle_bclk_t4", 0, {31'd0, bclk[0]}, 32'd0);
                     cmp("idle_ur_t4", 0, {31'd0, ur[0]}, 32'd1);
                     cmp("div8_bclk_t4", 1, {31'd0, bclk[1]}, 32'd1);
        wait_t(5);   cmp("idle_ur_t5", 0, {31'd0, ur[0]}, 32'd0);
        wait_t(8);   cmp("div8_fs_t8", 1, {31'd0, fs[1]}, 32'd1);
        wait_t(67);  cmp("idle_lr_t67", 0, {31'd0, lrclk[0]}, 32'd0);
        wait_t(68);  cmp("idle_lr_t68", 0, {31'd0, lrclk[0]}, 32'd1);
        wait_t(132); cmp("idle_ur_t132", 0, {31'd0, ur[0]}, 32'd1);
        wait_t(136); cmp("div8_lr_t136", 1, {31'd0, lrclk[1]}, 32'd1);
        wait_t(264); cmp("div8_fs_t264", 1, {31'd0, fs[1]}, 32'd1);

        // single frame A5C3 / 8001
        do_reset();
        valid = 1'b1; left = 16'hA5C3; right = 16'h8001;
        wait_t(1);
        valid = 1'b0;
        wait_t(4);
        cmp("single_fs", 0, {31'd0, fs[0]}, 32'd1);
        cmp("single_ur", 0, {31'd0, ur[0]}, 32'd0);
        bits = 16'h0;
        for (int k = 1; k <= 16; k++) begin
            wait_t(4 + 4 * k);
            bits = {bits[14:0], sdata[0]};
        end
        cmp("single_left", 0, {16'd0, bits}, 32'h0000A5C3);
        bits = 16'h0;
        for (int k = 17; k <= 31; k++) begin
            wait_t(4 + 4 * k);
            bits = {bits[14:0], sdata[0]};
        end
        cmp("single_right_hi", 0, {16'd0, bits}, 32'h00004000);
        wait_t(132);
        cmp("single_lsb", 0, {31'd0, sdata[0]}, 32'd1);

        // back-pressure: valid held, incrementing pattern
        do_reset();
        n_acc = 0; cnt = 16'd1;
        valid = 1'b1; left = cnt; right = ~cnt;
        for (int c = 0; c < 520; c++) begin
            r = rdy[0];
            if (t[0] == 2) cmp("bp_ready_drop", 0, {31'd0, rdy[0]}, 32'd0);
            wait_t(t[0] + 1);
            if (r) begin
                n_acc++;
                cnt = cnt + 16'd1;
                left = cnt; right = ~cnt;
            end
        end
        valid = 1'b0;
        cmp("bp_accepts", 0, n_acc, 32'd6);

        // late sample on the load cycle
        do_reset();
        wait_t(3);
        valid = 1'b1; left = 16'h1234; right = 16'h5678;
        wait_t(4);
        valid = 1'b0;
        cmp("late_ur", 0, {31'd0, ur[0]}, 32'd1);
        bits = 16'h0;
        for (int k = 1; k <= 16; k++) begin
            wait_t(132 + 4 * k);
            bits = {bits[14:0], sdata[0]};
        end
        cmp("late_left", 0, {16'd0, bits}, 32'h00001234);

        // mid-frame reset at slot 9
        do_reset();
        valid = 1'b1; left = 16'hFFFF; right = 16'hFFFF;
        wait_t(1);
        valid = 1'b0;
        wait_t(42);
        cmp("mid_pre_bclk", 0, {31'd0, bclk[0]}, 32'd1);
        cmp("mid_pre_sdata", 0, {31'd0, sdata[0]}, 32'd1);
        rst_n = 1'b0;
        #1;
        cmp("mid_rst_out", 0, {26'd0, bclk[0], lrclk[0], sdata[0], fs[0], ur[0], rdy[0]}, 32'd0);
        cmp("mid_rst_out", 1, {26'd0, bclk[1], lrclk[1], sdata[1], fs[1], ur[1], rdy[1]}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        wait_t(2); cmp("mid_bclk_t2", 0, {31'd0, bclk[0]}, 32'd1);
        wait_t(4); cmp("mid_ur_t4", 0, {31'd0, ur[0]}, 32'd1);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            valid = ($urandom_range(0, 99) < 2);
            left  = 16'($urandom);
            right = 16'($urandom);
            wait_t(t[0] + 1);
        end
        valid = 1'b0;
        wait_t(t[0] + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time %0t exceeded bound", $time);
        $fatal(1, "watchdog");
    end

endmodule
